// File: rtl/lif_layer_sequencer.sv
// Sequencer for one LIF layer: byte-wise weight load, timed ce run, spike capture.
// Optional per-neuron saturating spike counters are enabled by LIF_LAYER_SEQ_SPIKE_CNT_EN.
module lif_layer_sequencer #(
    parameter int N_STAGE    = 3,
    parameter int NEURON_NUM = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_valid,
    input  logic [7:0]                              cfg_data,
    output logic                                    cfg_ready,
    input  logic                                    start,
    input  logic [7:0]                              num_steps,
    output logic [NEURON_NUM*(2**N_STAGE)-1:0]      w,
    output logic                                    ce,
    input  logic [NEURON_NUM-1:0]                   spike_in,
    output logic                                    busy,
    output logic                                    done,
`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
    output logic [4*NEURON_NUM-1:0]                 spike_cnt,
`endif
    output logic [NEURON_NUM-1:0]                   spike_flags
);

    localparam int W_BITS  = NEURON_NUM * (2**N_STAGE);
    localparam int W_BYTES = W_BITS / 8;
    localparam int BC_W    = (W_BYTES > 1) ? $clog2(W_BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(W_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [7:0]            r_step_cnt;
    logic [BC_W-1:0]       r_byte_cnt;
    logic [W_BITS-1:0]     r_shadow;
    logic [W_BITS-1:0]     w_shadow_upd;
    logic [W_BITS-1:0]     r_w;
    logic                  r_ce_q;
    logic                  r_done;
    logic [NEURON_NUM-1:0] r_flags;
    logic                  w_start_acc;
    logic                  w_cfg_fire;

    // start only counts when no partial weight load is pending, and it pre-empts a byte
    assign w_start_acc = (r_state == S_IDLE) && start && (r_byte_cnt == '0);
    assign cfg_ready   = (r_state == S_IDLE) && !w_start_acc;
    assign w_cfg_fire  = cfg_valid && cfg_ready;

    assign ce          = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign w           = r_w;
    assign spike_flags = r_flags;

    always_comb begin
        w_shadow_upd = r_shadow;
        w_shadow_upd[int'(r_byte_cnt) * 8 +: 8] = cfg_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc)
                    w_state_nxt = (num_steps == 8'd0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (r_step_cnt == 8'd1)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_step_cnt <= '0;
            r_ce_q     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ce_q  <= ce;
            r_done  <= (r_state == S_DRAIN);
            if (w_start_acc)
                r_step_cnt <= num_steps;
            else if (r_state == S_RUN)
                r_step_cnt <= r_step_cnt - 8'd1;
        end
    end

    // w only moves on the final byte, taking the shadow with that byte merged in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_byte_cnt <= '0;
            r_w        <= '0;
        end else if (w_cfg_fire) begin
            r_shadow <= w_shadow_upd;
            if (r_byte_cnt == LAST_BYTE) begin
                r_byte_cnt <= '0;
                r_w        <= w_shadow_upd;
            end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags <= '0;
        else if (w_start_acc)
            r_flags <= '0;
        else if (r_ce_q)
            r_flags <= r_flags | spike_in;
    end

`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
    logic [4*NEURON_NUM-1:0] r_spike_cnt;

    assign spike_cnt = r_spike_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_cnt <= '0;
        end else if (w_start_acc) begin
            r_spike_cnt <= '0;
        end else if (r_ce_q) begin
            for (int unsigned i = 0; i < NEURON_NUM; i++) begin
                if (spike_in[i] && (r_spike_cnt[4*i +: 4] != 4'hF))
                    r_spike_cnt[4*i +: 4] <= r_spike_cnt[4*i +: 4] + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lif_layer_sequencer.sv
// Directed bench for lif_layer_sequencer (N_STAGE=3, NEURON_NUM=4): cycle table plus
// hand sequences for partial load, saturation, zero-step and mid-run reset.
module tb_lif_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        start;
    logic [7:0]  num_steps;
    logic [31:0] w;
    logic        ce;
    logic [3:0]  spike_in;
    logic        busy;
    logic        done;
    logic [3:0]  spike_flags;
`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
    logic [15:0] spike_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lif_layer_sequencer #(.N_STAGE(3), .NEURON_NUM(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .start       (start),
        .num_steps   (num_steps),
        .w           (w),
        .ce          (ce),
        .spike_in    (spike_in),
        .busy        (busy),
        .done        (done),
`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
        .spike_cnt   (spike_cnt),
`endif
        .spike_flags (spike_flags)
    );

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        st;
        logic [7:0]  ns;
        logic [3:0]  sp;
        logic        ce;
        logic        busy;
        logic        done;
        logic        rdy;
        logic [31:0] w;
        logic [3:0]  flg;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic vld, input logic [7:0] data, input logic st,
                                input logic [7:0] ns, input logic [3:0] sp, input logic e_ce,
                                input logic e_busy, input logic e_done, input logic e_rdy,
                                input logic [31:0] e_w, input logic [3:0] e_flg,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.vld = vld; v.data = data; v.st = st; v.ns = ns; v.sp = sp;
        v.ce = e_ce; v.busy = e_busy; v.done = e_done; v.rdy = e_rdy;
        v.w = e_w; v.flg = e_flg; v.cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cfg_valid = 1'b1;
        cfg_data  = b;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Pulses start for one cycle, then counts ce cycles until done (bounded).
    task automatic run_and_wait(input logic [7:0] ns, output int ce_cycles);
        bit seen;
        ce_cycles = 0;
        seen      = 1'b0;
        start     = 1'b1;
        num_steps = ns;
        tick();
        start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (ce) ce_cycles++;
            tick();
        end
        chk("done_within_bound", 32'(seen), 32'd1);
    endtask

    localparam logic [31:0] W1 = 32'h4433_2211;

    initial begin
        int nce;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; start = 1'b0;
        num_steps = '0; spike_in = '0;

        tbl[0]  = mk(0, 8'h00, 0, 8'd0, 4'b0000, 0, 0, 0, 1, 32'h0, 4'b0000, 16'h0000);
        tbl[1]  = mk(1, 8'h11, 0, 8'd0, 4'b0000, 0, 0, 0, 1, 32'h0, 4'b0000, 16'h0000);
        tbl[2]  = mk(1, 8'h22, 0, 8'd0, 4'b0000, 0, 0, 0, 1, 32'h0, 4'b0000, 16'h0000);
        tbl[3]  = mk(1, 8'h33, 0, 8'd0, 4'b0000, 0, 0, 0, 1, 32'h0, 4'b0000, 16'h0000);
        tbl[4]  = mk(1, 8'h44, 0, 8'd0, 4'b0000, 0, 0, 0, 1, 32'h0, 4'b0000, 16'h0000);
        tbl[5]  = mk(0, 8'h00, 1, 8'd5, 4'b0000, 0, 0, 0, 0, W1,    4'b0000, 16'h0000);
        tbl[6]  = mk(0, 8'h00, 0, 8'd0, 4'b1000, 1, 1, 0, 0, W1,    4'b0000, 16'h0000);
        tbl[7]  = mk(0, 8'h00, 0, 8'd0, 4'b0101, 1, 1, 0, 0, W1,    4'b0000, 16'h0000);
        tbl[8]  = mk(1, 8'hEE, 0, 8'd0, 4'b0000, 1, 1, 0, 0, W1,    4'b0101, 16'h0101);
        tbl[9]  = mk(0, 8'h00, 0, 8'd0, 4'b0101, 1, 1, 0, 0, W1,    4'b0101, 16'h0101);
        tbl[10] = mk(0, 8'h00, 0, 8'd0, 4'b0000, 1, 1, 0, 0, W1,    4'b0101, 16'h0202);
        tbl[11] = mk(0, 8'h00, 0, 8'd0, 4'b0000, 0, 1, 0, 0, W1,    4'b0101, 16'h0202);
        tbl[12] = mk(0, 8'h00, 0, 8'd0, 4'b0010, 0, 0, 1, 1, W1,    4'b0101, 16'h0202);
        tbl[13] = mk(0, 8'h00, 1, 8'd0, 4'b0000, 0, 0, 0, 0, W1,    4'b0101, 16'h0202);
        tbl[14] = mk(0, 8'h00, 0, 8'd0, 4'b1111, 0, 1, 0, 0, W1,    4'b0000, 16'h0000);
        tbl[15] = mk(0, 8'h00, 1, 8'd1, 4'b1111, 0, 0, 1, 0, W1,    4'b0000, 16'h0000);
        tbl[16] = mk(0, 8'h00, 0, 8'd0, 4'b0000, 1, 1, 0, 0, W1,    4'b0000, 16'h0000);
        tbl[17] = mk(0, 8'h00, 0, 8'd0, 4'b0100, 0, 1, 0, 0, W1,    4'b0000, 16'h0000);
        tbl[18] = mk(0, 8'h00, 0, 8'd0, 4'b0000, 0, 0, 1, 1, W1,    4'b0100, 16'h0100);

        tick();
        tick();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_w", w, 32'h0);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'(spike_flags), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cfg_valid = tbl[i].vld;
            cfg_data  = tbl[i].data;
            start     = tbl[i].st;
            num_steps = tbl[i].ns;
            spike_in  = tbl[i].sp;
            #1;
            chk($sformatf("row%0d_ce", i), 32'(ce), 32'(tbl[i].ce));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("row%0d_cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_w", i), w, tbl[i].w);
            chk($sformatf("row%0d_flags", i), 32'(spike_flags), 32'(tbl[i].flg));
`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
            chk($sformatf("row%0d_cnt", i), 32'(spike_cnt), 32'(tbl[i].cnt));
`endif
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0; start = 1'b0; spike_in = '0;

        // start during a partial load is ignored and does not steal the pending byte slot
        send_byte(8'hAA);
        send_byte(8'hBB);
        start = 1'b1; num_steps = 8'd3;
        #1;
        chk("partial_start_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        start = 1'b0;
        chk("partial_start_busy", 32'(busy), 32'd0);
        tick();
        chk("partial_start_busy2", 32'(busy), 32'd0);
        chk("partial_ce", 32'(ce), 32'd0);
        send_byte(8'hCC);
        chk("partial_w_hold", w, W1);
        send_byte(8'hDD);
        chk("partial_w_commit", w, 32'hDDCC_BBAA);

        // 20 spiking steps on neuron 0 saturate its counter
        spike_in = 4'b0001;
        run_and_wait(8'd20, nce);
        chk("sat_ce_cycles", 32'(nce), 32'd20);
        chk("sat_flags", 32'(spike_flags), 32'h1);
`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
        chk("sat_cnt", 32'(spike_cnt), 32'h000F);
`endif
        spike_in = '0;
        tick();

        // asynchronous reset in the middle of a 10-step run
        spike_in = 4'b1111;
        start = 1'b1; num_steps = 8'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrun_pre_ce", 32'(ce), 32'd1);
        chk("midrun_pre_flags", 32'(spike_flags), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_ce", 32'(ce), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_flags", 32'(spike_flags), 32'd0);
        chk("midrun_rst_w", w, 32'h0);
        chk("midrun_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        spike_in = '0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("reload_w_hold", w, 32'h0);
        send_byte(8'h04);
        chk("reload_w", w, 32'h0403_0201);
        spike_in = 4'b0010;
        run_and_wait(8'd2, nce);
        chk("rerun_ce_cycles", 32'(nce), 32'd2);
        chk("rerun_flags", 32'(spike_flags), 32'h2);
`ifdef LIF_LAYER_SEQ_SPIKE_CNT_EN
        chk("rerun_cnt", 32'(spike_cnt), 32'h0020);
`endif
        tick();
        chk("rerun_done_pulse", 32'(done), 32'd0);
        chk("rerun_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
